// File: rtl/memory_map_responder_pkg.sv
// Package: memory_map_responder_pkg
// Purpose: shared constants, address map and types for the CPU-side memory
//          responder. Also provides the CPU address decoder used by the top.
// Contents:
//   - sizes of work RAM and display banks, physical index layout of nibble_ram
//   - CPU address map constants (work RAM, display banks, factor/mask, I/O window)
//   - init_state_t : post-reset zero-fill FSM states
//   - region_t / decode_t and decode_addr() : CPU address decode result
package memory_map_responder_pkg;

  localparam int RAM_WORDS  = 640;
  localparam int DISP_WORDS = 80;
  localparam int MEM_WORDS  = RAM_WORDS + 2 * DISP_WORDS;  // 800 nibbles
  localparam int IDX_W      = 10;

  // Physical layout inside nibble_ram: work RAM, then bank0, then bank1.
  localparam logic [IDX_W-1:0] DISP0_IDX = IDX_W'(RAM_WORDS);
  localparam logic [IDX_W-1:0] DISP1_IDX = IDX_W'(RAM_WORDS + DISP_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MEM_WORDS - 1);

  // Video index limit: 0..79 bank0, 80..159 bank1.
  localparam logic [7:0] VIDEO_LIMIT = 8'(2 * DISP_WORDS);

  // CPU address map.
  localparam logic [11:0] MEM_RAM_END = 12'h27F;
  localparam logic [11:0] DISP0_BASE  = 12'hE00;
  localparam logic [11:0] DISP0_END   = 12'hE4F;
  localparam logic [11:0] DISP1_BASE  = 12'hE80;
  localparam logic [11:0] DISP1_END   = 12'hECF;
  localparam logic [11:0] FACTOR_BASE = 12'hF00;
  localparam logic [11:0] MASK_BASE   = 12'hF10;
  localparam logic [11:0] IO_FWD_BASE = 12'hF04;
  localparam logic [11:0] IO_END      = 12'hF7F;

  typedef enum logic {INIT_CLEAR, INIT_RUN} init_state_t;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_FACTOR,
    REG_MASK,
    REG_IO
  } region_t;

  typedef struct packed {
    region_t          region;
    logic [IDX_W-1:0] ram_idx;   // physical nibble_ram index when region==REG_RAM
    logic [1:0]       reg_sel;   // factor/mask register number
  } decode_t;

  // Factor and mask registers are tested before the I/O window so that
  // 0xF10..0xF13 are never forwarded even though they lie inside it.
  function automatic decode_t decode_addr(input logic [11:0] addr);
    decode_t d;
    d.region  = REG_NONE;
    d.ram_idx = '0;
    d.reg_sel = addr[1:0];
    if (addr <= MEM_RAM_END) begin
      d.region  = REG_RAM;
      d.ram_idx = addr[IDX_W-1:0];
    end else if (addr >= DISP0_BASE && addr <= DISP0_END) begin
      d.region  = REG_RAM;
      d.ram_idx = DISP0_IDX + {3'b000, addr[6:0]};
    end else if (addr >= DISP1_BASE && addr <= DISP1_END) begin
      d.region  = REG_RAM;
      d.ram_idx = DISP1_IDX + {3'b000, addr[6:0]};
    end else if (addr[11:2] == FACTOR_BASE[11:2]) begin
      d.region = REG_FACTOR;
    end else if (addr[11:2] == MASK_BASE[11:2]) begin
      d.region = REG_MASK;
    end else if (addr >= IO_FWD_BASE && addr <= IO_END) begin
      d.region = REG_IO;
    end
    return d;
  endfunction

endpackage

// File: rtl/memory_map_responder_nibble_ram.sv
// Module: memory_map_responder_nibble_ram (the nibble_ram storage)
// Purpose: DEPTH x 4-bit memory with one read/write port (A) and one
//          read-only port (B). Both read ports are registered; port A is
//          read-before-write, and port B sees the old value when A writes
//          the same word on the same edge.
// Ports:
//   clk      in   clock
//   a_we     in   port A write enable
//   a_addr   in   port A index
//   a_wdata  in   port A write data
//   a_rdata  out  port A registered read data
//   b_addr   in   port B index
//   b_rdata  out  port B registered read data
module memory_map_responder_nibble_ram
  import memory_map_responder_pkg::*;
#(
  parameter int DEPTH = MEM_WORDS,
  parameter int AW    = IDX_W
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [3:0]    a_wdata,
  output logic [3:0]    a_rdata,
  input  logic [AW-1:0] b_addr,
  output logic [3:0]    b_rdata
);

  logic [3:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_wdata;
    end
    a_rdata <= mem[a_addr];
  end

  always_ff @(posedge clk) begin
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/memory_map_responder.sv
// Module: memory_map_responder
// Purpose: memory-side responder for the CPU data bus. Decodes the 12-bit
//          nibble address space into work RAM, two display banks, interrupt
//          factor/mask registers and a forwarded I/O window. Provides a
//          read-only video port into display RAM and zero-fills all RAM after
//          reset while init_busy is high.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   memory_write_en/addr/wdata    CPU write strobe, nibble address, data
//   memory_read_data              registered CPU read data (1-cycle latency)
//   init_busy                     high during the post-reset zero-fill
//   video_addr / video_data       display index 0..159 / registered nibble
//   int_set                       per-bit factor set pulses, 4 groups of 4
//   interrupt_pending             per group (factor & mask) != 0
//   io_write_en/addr/write_data   forwarded write for the I/O window
//   io_read_data                  peripheral read data for the I/O window
module memory_map_responder
  import memory_map_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memory_write_en,
  input  logic [11:0] memory_addr,
  input  logic [3:0]  memory_write_data,
  output logic [3:0]  memory_read_data,
  output logic        init_busy,
  input  logic [7:0]  video_addr,
  output logic [3:0]  video_data,
  input  logic [15:0] int_set,
  output logic [3:0]  interrupt_pending,
  output logic        io_write_en,
  output logic [6:0]  io_addr,
  output logic [3:0]  io_write_data,
  input  logic [3:0]  io_read_data
);

  init_state_t      state_reg;
  logic [IDX_W-1:0] fill_idx_reg;
  logic             init_busy_reg;
  decode_t          dec;
  logic             run;

  assign dec       = decode_addr(memory_addr);
  assign run       = (state_reg == INIT_RUN);
  assign init_busy = init_busy_reg;

  // Zero-fill FSM: one word per clock, RUN is terminal until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= INIT_CLEAR;
      fill_idx_reg  <= '0;
      init_busy_reg <= 1'b1;
    end else begin
      case (state_reg)
        INIT_CLEAR: begin
          if (fill_idx_reg == LAST_IDX) begin
            state_reg     <= INIT_RUN;
            init_busy_reg <= 1'b0;
          end else begin
            fill_idx_reg <= fill_idx_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= INIT_RUN;
        end
      endcase
    end
  end

  // Port A belongs to the fill engine during CLEAR, so CPU writes are dropped.
  logic             ram_a_we;
  logic [IDX_W-1:0] ram_a_addr;
  logic [3:0]       ram_a_wdata;
  logic [3:0]       ram_a_rdata;
  logic [IDX_W-1:0] ram_b_addr;
  logic [3:0]       ram_b_rdata;
  logic             video_in_range;

  always_comb begin
    ram_a_we    = 1'b0;
    ram_a_addr  = dec.ram_idx;
    ram_a_wdata = memory_write_data;
    if (!run) begin
      ram_a_we    = 1'b1;
      ram_a_addr  = fill_idx_reg;
      ram_a_wdata = 4'h0;
    end else if (dec.region == REG_RAM) begin
      ram_a_we = memory_write_en;
    end
  end

  // Display banks are contiguous in nibble_ram, so the video index maps
  // directly onto DISP0_IDX + video_addr. Out-of-range indices park on a
  // valid word and are masked at the output.
  assign video_in_range = (video_addr < VIDEO_LIMIT);
  assign ram_b_addr     = video_in_range ? (DISP0_IDX + {2'b00, video_addr}) : DISP0_IDX;

  memory_map_responder_nibble_ram #(
    .DEPTH(MEM_WORDS),
    .AW   (IDX_W)
  ) u_nibble_ram (
    .clk    (clk),
    .a_we   (ram_a_we),
    .a_addr (ram_a_addr),
    .a_wdata(ram_a_wdata),
    .a_rdata(ram_a_rdata),
    .b_addr (ram_b_addr),
    .b_rdata(ram_b_rdata)
  );

  // Interrupt factor and mask registers, one group per generate iteration.
  logic [15:0] factor_flat;
  logic [15:0] mask_flat;

  for (genvar gi = 0; gi < 4; gi++) begin : g_int
    logic [3:0] factor_reg;
    logic [3:0] mask_reg;
    logic       factor_clr;
    logic       mask_wr;

    // Any RUN-state cycle addressing the factor register is a read of it,
    // so it clears; set pulses on the same edge still win.
    assign factor_clr = run && (dec.region == REG_FACTOR) && (dec.reg_sel == 2'(gi));
    assign mask_wr    = run && memory_write_en && (dec.region == REG_MASK) &&
                        (dec.reg_sel == 2'(gi));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        factor_reg <= 4'h0;
        mask_reg   <= 4'h0;
      end else begin
        factor_reg <= (factor_clr ? 4'h0 : factor_reg) | int_set[gi*4 +: 4];
        if (mask_wr) begin
          mask_reg <= memory_write_data;
        end
      end
    end

    assign factor_flat[gi*4 +: 4] = factor_reg;
    assign mask_flat[gi*4 +: 4]   = mask_reg;
    assign interrupt_pending[gi]  = |(factor_reg & mask_reg);
  end

  // Read path: RAM data comes from nibble_ram's own output register, all
  // other sources are captured here; a registered select picks between them.
  logic [3:0] reg_rdata_next;
  logic [3:0] reg_rdata_reg;
  logic       ram_sel_reg;
  logic       video_sel_reg;

  always_comb begin
    reg_rdata_next = 4'h0;
    case (dec.region)
      REG_FACTOR: reg_rdata_next = factor_flat[{dec.reg_sel, 2'b00} +: 4];
      REG_MASK:   reg_rdata_next = mask_flat[{dec.reg_sel, 2'b00} +: 4];
      REG_IO:     reg_rdata_next = io_read_data;
      default:    reg_rdata_next = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_rdata_reg <= 4'h0;
      ram_sel_reg   <= 1'b0;
      video_sel_reg <= 1'b0;
    end else begin
      reg_rdata_reg <= run ? reg_rdata_next : 4'h0;
      ram_sel_reg   <= run && (dec.region == REG_RAM);
      video_sel_reg <= run && video_in_range;
    end
  end

  assign memory_read_data = ram_sel_reg ? ram_a_rdata : reg_rdata_reg;
  assign video_data       = video_sel_reg ? ram_b_rdata : 4'h0;

  // Forwarded I/O window.
  assign io_write_en   = run && memory_write_en && (dec.region == REG_IO);
  assign io_addr       = memory_addr[6:0];
  assign io_write_data = memory_write_data;

endmodule

// File: tb/tb_memory_map_responder.sv
// Testbench: tb_memory_map_responder
// Purpose: drives memory_map_responder with directed steps and random traffic
//          and compares every cycle against an address-level reference model
//          (memory indexed by CPU address, factor/mask arrays, fill counter).
module tb_memory_map_responder;

  logic        clk;
  logic        reset_n;
  logic        memory_write_en;
  logic [11:0] memory_addr;
  logic [3:0]  memory_write_data;
  logic [3:0]  memory_read_data;
  logic        init_busy;
  logic [7:0]  video_addr;
  logic [3:0]  video_data;
  logic [15:0] int_set;
  logic [3:0]  interrupt_pending;
  logic        io_write_en;
  logic [6:0]  io_addr;
  logic [3:0]  io_write_data;
  logic [3:0]  io_read_data;

  memory_map_responder dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .memory_write_en  (memory_write_en),
    .memory_addr      (memory_addr),
    .memory_write_data(memory_write_data),
    .memory_read_data (memory_read_data),
    .init_busy        (init_busy),
    .video_addr       (video_addr),
    .video_data       (video_data),
    .int_set          (int_set),
    .interrupt_pending(interrupt_pending),
    .io_write_en      (io_write_en),
    .io_addr          (io_addr),
    .io_write_data    (io_write_data),
    .io_read_data     (io_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [3:0] cpu_mem [4096];
  logic [3:0] fac [4];
  logic [3:0] msk [4];
  bit         model_run;
  int         cycles_since_reset;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_ram_addr(input logic [11:0] a);
    return (a <= 12'h27F) || (a >= 12'hE00 && a <= 12'hE4F) ||
           (a >= 12'hE80 && a <= 12'hECF);
  endfunction

  function automatic bit is_factor(input logic [11:0] a);
    return a >= 12'hF00 && a <= 12'hF03;
  endfunction

  function automatic bit is_mask(input logic [11:0] a);
    return a >= 12'hF10 && a <= 12'hF13;
  endfunction

  function automatic bit is_io(input logic [11:0] a);
    return a >= 12'hF04 && a <= 12'hF7F && !is_mask(a);
  endfunction

  function automatic logic [3:0] model_read(input logic [11:0] a);
    if (is_ram_addr(a)) return cpu_mem[a];
    if (is_factor(a))   return fac[a[1:0]];
    if (is_mask(a))     return msk[a[1:0]];
    if (is_io(a))       return io_read_data;
    return 4'h0;
  endfunction

  function automatic logic [3:0] model_video(input logic [7:0] va);
    if (va < 8'd80)  return cpu_mem[12'hE00 + 12'(va)];
    if (va < 8'd160) return cpu_mem[12'hE80 + 12'(va) - 12'd80];
    return 4'h0;
  endfunction

  function automatic logic [3:0] model_pending();
    logic [3:0] p;
    for (int g = 0; g < 4; g++) p[g] = |(fac[g] & msk[g]);
    return p;
  endfunction

  // One clock: predict from pre-edge state, advance the model, check outputs.
  task automatic tick();
    logic [3:0]  exp_rd;
    logic [3:0]  exp_vd;
    logic [11:0] a;
    #1;
    check("io_we", {15'h0, io_write_en},
          {15'h0, model_run && memory_write_en && is_io(memory_addr)});
    exp_rd = model_run ? model_read(memory_addr) : 4'h0;
    exp_vd = model_run ? model_video(video_addr) : 4'h0;
    @(posedge clk);
    a = memory_addr;
    if (model_run) begin
      if (memory_write_en && is_ram_addr(a)) cpu_mem[a] = memory_write_data;
      if (memory_write_en && is_mask(a))     msk[a[1:0]] = memory_write_data;
      if (is_factor(a))                      fac[a[1:0]] = 4'h0;
    end
    for (int g = 0; g < 4; g++) fac[g] = fac[g] | int_set[g*4 +: 4];
    if (!model_run) begin
      cycles_since_reset++;
      if (cycles_since_reset >= 800) model_run = 1'b1;
    end
    #1;
    check("rd_data", {12'h0, memory_read_data}, {12'h0, exp_rd});
    check("video",   {12'h0, video_data}, {12'h0, exp_vd});
    check("busy",    {15'h0, init_busy}, {15'h0, !model_run});
    check("pending", {12'h0, interrupt_pending}, {12'h0, model_pending()});
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4096; i++) cpu_mem[i] = 4'h0;
    for (int g = 0; g < 4; g++) begin
      fac[g] = 4'h0;
      msk[g] = 4'h0;
    end
    model_run          = 1'b0;
    cycles_since_reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd",      {12'h0, memory_read_data}, 16'h0);
    check("rst_video",   {12'h0, video_data}, 16'h0);
    check("rst_busy",    {15'h0, init_busy}, 16'h1);
    check("rst_pending", {12'h0, interrupt_pending}, 16'h0);
    reset_n = 1'b1;
  endtask

  // Runs the fill with optional lost CPU writes; checks its length.
  task automatic run_fill(input bit with_writes);
    int n;
    n = 0;
    do begin
      memory_write_en   = with_writes;
      memory_addr       = 12'h010 + 12'(n % 16);
      memory_write_data = 4'(n % 15 + 1);
      tick();
      n++;
    end while (init_busy && n < 2000);
    memory_write_en = 1'b0;
    check("busy_len", 16'(n), 16'd800);
  endtask

  initial begin
    reset_n           = 1'b0;
    memory_write_en   = 1'b0;
    memory_addr       = 12'h000;
    memory_write_data = 4'h0;
    video_addr        = 8'd0;
    int_set           = 16'h0;
    io_read_data      = 4'h0;

    // Power-up fill and zeroed reads.
    apply_reset();
    run_fill(1'b0);
    memory_addr = 12'h000; tick(); check("rd_000", {12'h0, memory_read_data}, 16'h0);
    memory_addr = 12'h27F; tick(); check("rd_27F", {12'h0, memory_read_data}, 16'h0);
    memory_addr = 12'hECF; tick(); check("rd_ECF", {12'h0, memory_read_data}, 16'h0);

    // Read-before-write.
    memory_addr = 12'h123; memory_write_en = 1'b1; memory_write_data = 4'h5;
    tick(); check("rbw_old", {12'h0, memory_read_data}, 16'h0);
    memory_write_en = 1'b0;
    tick(); check("rbw_new", {12'h0, memory_read_data}, 16'h5);

    // Interrupt factor, mask and clear-on-read.
    memory_addr = 12'hF10; memory_write_en = 1'b1; memory_write_data = 4'h4;
    tick();
    memory_write_en = 1'b0; memory_addr = 12'h300; int_set = 16'h0004;
    tick(); int_set = 16'h0;
    check("pend_set", {15'h0, interrupt_pending[0]}, 16'h1);
    memory_addr = 12'hF00;
    tick();
    check("fac_read", {12'h0, memory_read_data}, 16'h4);
    check("pend_clr", {15'h0, interrupt_pending[0]}, 16'h0);
    memory_addr = 12'h300; int_set = 16'h0004;
    tick();
    memory_addr = 12'hF00;
    tick(); int_set = 16'h0;
    check("fac_read2",  {12'h0, memory_read_data}, 16'h4);
    check("set_wins",   {15'h0, interrupt_pending[0]}, 16'h1);
    tick();
    check("pend_clr2",  {15'h0, interrupt_pending[0]}, 16'h0);

    // Display RAM through the video port; unmapped gap write.
    memory_addr = 12'hE85; memory_write_en = 1'b1; memory_write_data = 4'hA; video_addr = 8'd85;
    tick(); check("vid_old", {12'h0, video_data}, 16'h0);
    memory_write_en = 1'b0;
    tick(); check("vid_new", {12'h0, video_data}, 16'hA);
    memory_addr = 12'hE50; memory_write_en = 1'b1; memory_write_data = 4'h3;
    tick(); memory_write_en = 1'b0;
    tick(); check("rd_E50", {12'h0, memory_read_data}, 16'h0);
    video_addr = 8'd79; tick(); check("vid_79", {12'h0, video_data}, 16'h0);
    video_addr = 8'd170; tick(); check("vid_170", {12'h0, video_data}, 16'h0);

    // I/O window forwarding.
    memory_addr = 12'hF40; memory_write_en = 1'b1; memory_write_data = 4'h6; io_read_data = 4'h9;
    #1;
    check("io_we_F40",   {15'h0, io_write_en}, 16'h1);
    check("io_addr_F40", {9'h0, io_addr}, 16'h40);
    check("io_wd_F40",   {12'h0, io_write_data}, 16'h6);
    tick(); check("io_rd_F40", {12'h0, memory_read_data}, 16'h9);
    memory_addr = 12'hF10; memory_write_data = 4'h2;
    #1; check("io_we_F10", {15'h0, io_write_en}, 16'h0);
    tick();
    memory_addr = 12'hF01;
    #1; check("io_we_F01", {15'h0, io_write_en}, 16'h0);
    tick();
    memory_write_en = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 6))
        0: memory_addr = 12'($urandom_range(0, 15));
        1: memory_addr = 12'h270 + 12'($urandom_range(0, 15));
        2: memory_addr = 12'hE00 + 12'($urandom_range(0, 127));
        3: memory_addr = 12'hE80 + 12'($urandom_range(0, 127));
        4: memory_addr = 12'hF00 + 12'($urandom_range(0, 31));
        5: memory_addr = 12'hF00 + 12'($urandom_range(0, 255));
        default: memory_addr = 12'($urandom_range(0, 4095));
      endcase
      memory_write_en   = 1'($urandom_range(0, 1));
      memory_write_data = 4'($urandom_range(0, 15));
      io_read_data      = 4'($urandom_range(0, 15));
      video_addr        = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 191))
                                                      : 8'($urandom_range(0, 15)) + 8'd80;
      for (int b = 0; b < 16; b++) int_set[b] = ($urandom_range(0, 7) == 0);
      tick();
    end
    memory_write_en = 1'b0;
    int_set         = 16'h0;

    // Reset in the middle of the fill; writes during the fill are lost.
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      memory_write_en = 1'b1; memory_addr = 12'h010; memory_write_data = 4'h7;
      tick();
    end
    memory_write_en = 1'b0;
    apply_reset();
    run_fill(1'b1);
    for (int i = 0; i < 16; i++) begin
      memory_addr = 12'h010 + 12'(i);
      tick();
      check("lost_write", {12'h0, memory_read_data}, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
